// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_RUN    = 2'd0,
        FETCH_HALTED = 2'd1,
        FETCH_FAULT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instr} pairs between fetch and decode; flush beats push/pop.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  push_entry,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full buffer can still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// RV32I fetch sequencer: owns the PC, reads combinational imem, feeds decode via valid/ready.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] Imem_Address,
    input  logic [31:0] Imem_Instruction,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_Target,
    input  logic        Halt,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Out_PC,
    output logic [31:0] Out_Instruction,
    output logic        Misaligned,
    output logic [31:0] Fault_PC
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   pc;
    logic [31:0]   pc_next;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [CW-1:0] buf_count;
    logic          buf_empty;
    logic          pop;
    logic          room;
    logic          fetch;
    logic          redirect_ok;
    logic          bad_target;

    assign Imem_Address    = pc;
    assign Out_Valid       = (state != FETCH_FAULT) && !buf_empty;
    assign Out_PC          = head.pc;
    assign Out_Instruction = head.instr;

    assign pop         = Out_Valid && Out_Ready;
    assign room        = (buf_count != CW'(DEPTH)) || pop;
    assign redirect_ok = Redirect_Valid && (state != FETCH_FAULT);
    assign bad_target  = |Redirect_Target[1:0];
    // A redirect in the same cycle kills the push, so the stale PC never enters the buffer.
    assign fetch       = (state == FETCH_RUN) && !Halt && !Redirect_Valid && room;
    assign push_entry  = '{pc: pc, instr: Imem_Instruction};

    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            FETCH_RUN: begin
                if (redirect_ok && bad_target)
                    state_next = FETCH_FAULT;
                else if (Halt)
                    state_next = FETCH_HALTED;
            end
            FETCH_HALTED: begin
                if (redirect_ok && bad_target)
                    state_next = FETCH_FAULT;
                else if (!Halt)
                    state_next = FETCH_RUN;
            end
            default: state_next = FETCH_FAULT;
        endcase
        if (redirect_ok && !bad_target)
            pc_next = Redirect_Target;
        else if (fetch)
            pc_next = pc + INSTR_BYTES;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= FETCH_RUN;
            pc         <= RESET_PC;
            Misaligned <= 1'b0;
            Fault_PC   <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (redirect_ok && bad_target) begin
                Misaligned <= 1'b1;
                Fault_PC   <= Redirect_Target;
            end
        end
    end

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk        (CLK),
        .rst        (RST),
        .push       (fetch),
        .pop        (pop),
        .flush      (redirect_ok),
        .push_entry (push_entry),
        .head       (head),
        .count      (buf_count),
        .empty      (buf_empty)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed, table-driven bench for fetch_controller with a combinational imem model.
module tb_fetch_controller;

    logic        CLK;
    logic        RST;
    logic        Redirect_Valid;
    logic [31:0] Redirect_Target;
    logic        Halt;
    logic        Out_Ready;

    logic [31:0] Imem_Address,  Imem_Instruction;
    logic        Out_Valid,  Misaligned;
    logic [31:0] Out_PC,  Out_Instruction,  Fault_PC;

    logic [31:0] Imem_Address2, Imem_Instruction2;
    logic        Out_Valid2, Misaligned2;
    logic [31:0] Out_PC2, Out_Instruction2, Fault_PC2;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] tb_imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h4000_0113;
            32'h0000_0004: return 32'h0080_0513;
            32'h0000_0008: return 32'h0100_00EF;
            32'h0000_0028: return 32'h0010_0313;
            32'h0000_0074: return 32'h0002_8513;
            32'h0000_0078: return 32'h0000_8067;
            default:       return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
        endcase
    endfunction

    assign Imem_Instruction  = tb_imem(Imem_Address);
    assign Imem_Instruction2 = tb_imem(Imem_Address2);

    fetch_controller #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .CLK(CLK), .RST(RST),
        .Imem_Address(Imem_Address), .Imem_Instruction(Imem_Instruction),
        .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
        .Halt(Halt), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_PC(Out_PC), .Out_Instruction(Out_Instruction),
        .Misaligned(Misaligned), .Fault_PC(Fault_PC)
    );

    fetch_controller #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut2 (
        .CLK(CLK), .RST(RST),
        .Imem_Address(Imem_Address2), .Imem_Instruction(Imem_Instruction2),
        .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
        .Halt(Halt), .Out_Valid(Out_Valid2), .Out_Ready(Out_Ready),
        .Out_PC(Out_PC2), .Out_Instruction(Out_Instruction2),
        .Misaligned(Misaligned2), .Fault_PC(Fault_PC2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          rst, rv;
        logic [31:0] rt;
        bit          halt, rdy, chk, ca, ev;
        logic [31:0] epc, eaddr;
        int          ecnt;
        bit          emis;
        logic [31:0] efpc;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(bit rst, bit rv, logic [31:0] rt, bit halt, bit rdy,
                              bit chk, bit ca, bit ev, logic [31:0] epc,
                              logic [31:0] eaddr, int ecnt, bit emis, logic [31:0] efpc);
        vec_t t;
        t = '{rst, rv, rt, halt, rdy, chk, ca, ev, epc, eaddr, ecnt, emis, efpc};
        vecs.push_back(t);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        RST = 1'b1; Redirect_Valid = 1'b0; Redirect_Target = '0; Halt = 1'b0; Out_Ready = 1'b0;

        // Reset state, then the wrapping-PC instance across its first fetches.
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        cmp("rst_valid", {31'b0, Out_Valid}, 32'd0);
        cmp("rst_pc", Out_PC, 32'd0);
        cmp("rst_instr", Out_Instruction, 32'd0);
        cmp("rst_mis", {31'b0, Misaligned}, 32'd0);
        cmp("rst_fpc", Fault_PC, 32'd0);
        cmp("rst_addr", Imem_Address, 32'd0);
        cmp("rst_cnt", 32'(dut.u_buf.count), 32'd0);
        cmp("rst_addr2", Imem_Address2, 32'hFFFF_FFFC);
        @(negedge CLK); RST = 1'b0; Out_Ready = 1'b1; #1;
        cmp("wrap_c0_valid", {31'b0, Out_Valid2}, 32'd0);
        @(negedge CLK); #1;
        cmp("wrap_c1_valid", {31'b0, Out_Valid2}, 32'd1);
        cmp("wrap_c1_pc", Out_PC2, 32'hFFFF_FFFC);
        cmp("wrap_c1_instr", Out_Instruction2, tb_imem(32'hFFFF_FFFC));
        @(negedge CLK); #1;
        cmp("wrap_c2_valid", {31'b0, Out_Valid2}, 32'd1);
        cmp("wrap_c2_pc", Out_PC2, 32'h0000_0000);
        cmp("wrap_c2_addr", Imem_Address2, 32'h0000_0004);

        // Streaming after reset at one instruction per cycle.
        v(1,0,0,0,1, 0,0,0, 0,0,0,0,0);
        v(0,0,0,0,1, 1,1,0, 32'h0, 32'h0, 0,0,0);
        v(0,0,0,0,1, 1,1,1, 32'h0, 32'h4, 1,0,0);
        v(0,0,0,0,1, 1,1,1, 32'h4, 32'h8, 1,0,0);
        v(0,0,0,0,1, 1,1,1, 32'h8, 32'hC, 1,0,0);
        // Backpressure for 5 cycles, then full-buffer push+pop and drain.
        v(1,0,0,0,0, 0,0,0, 0,0,0,0,0);
        v(0,0,0,0,0, 1,1,0, 32'h0, 32'h0, 0,0,0);
        v(0,0,0,0,0, 1,1,1, 32'h0, 32'h4, 1,0,0);
        v(0,0,0,0,0, 1,1,1, 32'h0, 32'h8, 2,0,0);
        v(0,0,0,0,0, 1,1,1, 32'h0, 32'h8, 2,0,0);
        v(0,0,0,0,0, 1,1,1, 32'h0, 32'h8, 2,0,0);
        v(0,0,0,0,1, 1,1,1, 32'h0, 32'h8, 2,0,0);
        v(0,0,0,0,1, 1,1,1, 32'h4, 32'hC, 2,0,0);
        v(0,0,0,0,1, 1,1,1, 32'h8, 32'h10, 2,0,0);
        // Redirect with two entries buffered.
        v(0,1,32'h28,0,0, 1,1,1, 32'hC, 32'h14, 2,0,0);
        v(0,0,0,0,1, 1,1,0, 32'h0, 32'h28, 0,0,0);
        v(0,0,0,0,1, 1,1,1, 32'h28, 32'h2C, 1,0,0);
        v(0,0,0,0,1, 1,1,1, 32'h2C, 32'h30, 1,0,0);
        // Halt drains the buffer, redirect while halted, then resume.
        v(1,0,0,0,0, 0,0,0, 0,0,0,0,0);
        v(0,0,0,0,0, 1,1,0, 32'h0, 32'h0, 0,0,0);
        v(0,0,0,0,0, 1,1,1, 32'h0, 32'h4, 1,0,0);
        v(0,0,0,1,0, 1,1,1, 32'h0, 32'h8, 2,0,0);
        v(0,0,0,1,1, 1,1,1, 32'h0, 32'h8, 2,0,0);
        v(0,0,0,1,1, 1,1,1, 32'h4, 32'h8, 1,0,0);
        v(0,0,0,1,1, 1,1,0, 32'h0, 32'h8, 0,0,0);
        v(0,1,32'h74,1,1, 1,1,0, 32'h0, 32'h8, 0,0,0);
        v(0,0,0,1,1, 1,1,0, 32'h0, 32'h74, 0,0,0);
        v(0,0,0,0,1, 1,1,0, 32'h0, 32'h74, 0,0,0);
        v(0,0,0,0,1, 1,1,0, 32'h0, 32'h74, 0,0,0);
        v(0,0,0,0,1, 1,1,1, 32'h74, 32'h78, 1,0,0);
        v(0,0,0,0,1, 1,1,1, 32'h78, 32'h7C, 1,0,0);
        // Misaligned redirect: sticky fault ignores redirect/halt until reset.
        v(0,1,32'h29,0,1, 1,1,1, 32'h7C, 32'h80, 1,0,0);
        for (int k = 0; k < 12; k++)
            v(0, k == 5, 32'h0, (k % 2) == 1, 1, 1,0,0, 32'h0, 32'h0, 0,1,32'h29);
        v(1,0,0,0,1, 0,0,0, 0,0,0,0,0);
        v(0,0,0,0,1, 1,1,0, 32'h0, 32'h0, 0,0,0);
        v(0,0,0,0,1, 1,1,1, 32'h0, 32'h4, 1,0,0);

        foreach (vecs[i]) begin
            @(negedge CLK);
            RST = vecs[i].rst; Redirect_Valid = vecs[i].rv; Redirect_Target = vecs[i].rt;
            Halt = vecs[i].halt; Out_Ready = vecs[i].rdy;
            #1;
            if (vecs[i].chk) begin
                cmp($sformatf("v%0d_valid", i), {31'b0, Out_Valid}, {31'b0, vecs[i].ev});
                if (vecs[i].ev) begin
                    cmp($sformatf("v%0d_pc", i), Out_PC, vecs[i].epc);
                    cmp($sformatf("v%0d_instr", i), Out_Instruction, tb_imem(vecs[i].epc));
                end
                if (vecs[i].ca)
                    cmp($sformatf("v%0d_addr", i), Imem_Address, vecs[i].eaddr);
                cmp($sformatf("v%0d_cnt", i), 32'(dut.u_buf.count), 32'(vecs[i].ecnt));
                cmp($sformatf("v%0d_mis", i), {31'b0, Misaligned}, {31'b0, vecs[i].emis});
                cmp($sformatf("v%0d_fpc", i), Fault_PC, vecs[i].efpc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
